weight_bank_streamer: RTL and testbench
=======================================

WEIGHT_BANK_STREAMER -- requirements
Module: weight_bank_streamer

Interface
REQ-001 SHALL have port: clk  input  1  single system clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-003 SHALL have port: address  input  2  target word slot for a load write, 0..3.
REQ-004 SHALL have port: writeData  input  1  load strobe; one word written per cycle while high.
REQ-005 SHALL have port: data_in  input  32  load word, bit 31 = MSB.
REQ-006 SHALL have port: start_network_controller  input  1  run request from loader; rising edge significant.
REQ-007 SHALL have port: weight_ready  input  1  downstream neuron accepts current word.
REQ-008 SHALL have port: weight_out  output  32  word currently offered downstream.
REQ-009 SHALL have port: weight_valid  output  1  weight_out/weight_index valid.
REQ-010 SHALL have port: weight_index  output  2  slot number of offered word.
REQ-011 SHALL have port: load_mask  output  4  bit i = slot i written since last run.
REQ-012 SHALL have port: busy  output  1  high in STREAM and DONE.
REQ-013 SHALL have port: done  output  1  one-cycle pulse after last word transferred.
REQ-014 SHALL have port: start_error  output  1  one-cycle pulse on rejected start (see Configuration).

Function
REQ-015 SHALL hold four 32-bit slot registers; writeData=1 in IDLE at edge N writes data_in to slot[address] and sets load_mask[address], visible at N+1.
REQ-016 SHALL ignore writeData while busy=1; slots and load_mask unchanged.
REQ-017 SHALL register start_network_controller and detect a rising edge (current 1, previous 0); a level held high starts exactly one run.
REQ-018 SHALL have states IDLE, STREAM, DONE; IDLE->STREAM on accepted start edge, STREAM->DONE on transfer of index 3, DONE->IDLE unconditionally after one cycle.
REQ-019 SHALL assert weight_valid=1, weight_index=0, weight_out=slot[0] on the first cycle of STREAM (one cycle after the start edge is detected).
REQ-020 SHALL count a transfer at an edge where weight_valid=1 and weight_ready=1; index then increments by 1 and weight_out updates to the new slot on the next cycle.
REQ-021 SHALL hold weight_out and weight_index stable while weight_valid=1 and weight_ready=0, for any number of cycles.
REQ-022 SHALL drive weight_valid=0 in IDLE and DONE; weight_out=0 when weight_valid=0.
REQ-023 SHALL, in DONE, pulse done=1 for exactly one cycle and clear load_mask to 4'b0000.
REQ-024 SHALL, on write and start edge in the same IDLE cycle, apply the write first; the run streams the updated slot.
REQ-025 SHALL ignore start edges while busy=1 (no restart, no error).
REQ-026 SHALL never wrap weight_index within a run; exactly four transfers per run.

Reset
REQ-027 SHALL, on reset=0 at any time including mid-run, immediately force state IDLE, all slots 0, load_mask 0, weight_index 0, weight_out 0, weight_valid 0, busy 0, done 0, start_error 0, start-edge register 0.
REQ-028 SHALL treat start_network_controller already high at reset release as a rising edge on the first sampled cycle.

Configuration
REQ-029 SHALL support macro WEIGHT_LOAD_CHECK_EN: when defined, a start edge in IDLE with load_mask != 4'b1111 is rejected, state stays IDLE, start_error pulses one cycle.
REQ-030 SHALL, without WEIGHT_LOAD_CHECK_EN, accept every IDLE start edge, stream unwritten slots as their reset value 0, and tie start_error to 0.

Verification
REQ-031 SHALL cover: reset, write slots 0..3 = 32'h11111111, 22222222, 33333333, 44444444, start pulse, weight_ready=1 -> four consecutive words in order, index 0..3, done one cycle after index 3, load_mask 0.
REQ-032 SHALL cover: same load, weight_ready toggled 1,0,0,1,0,1,1 -> each word held stable while ready=0, exactly four transfers, no duplicate or skip.
REQ-033 SHALL cover: slots 0..2 written only, start pulse -> with WEIGHT_LOAD_CHECK_EN start_error=1 one cycle and busy stays 0; without it word 3 streams as 32'h00000000.
REQ-034 SHALL cover: start held high 10 cycles and writeData=1 to slot 1 with 32'hDEADBEEF during STREAM -> exactly one run, slot 1 unchanged, next run still shows old value.
REQ-035 SHALL cover: reset=0 asserted while weight_index=2 -> all outputs 0 same cycle, load_mask 0, no done pulse after release.
REQ-036 SHALL cover: write slot 0 = 32'hCAFEF00D coincident with start edge (all slots loaded) -> first streamed word is 32'hCAFEF00D.

Source files
------------

// File: rtl/weight_bank_streamer.sv
// Weight bank streamer: four 32-bit weight slots are loaded while idle, then a
// rising edge on start_network_controller streams slots 0..3 downstream over a
// valid/ready handshake, followed by a one-cycle done pulse.
// Optional build macro WEIGHT_LOAD_CHECK_EN: reject a start unless all four slots
// have been written since the last run (start_error pulses instead).
module weight_bank_streamer (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        writeData,
  input  logic [31:0] data_in,
  input  logic        start_network_controller,
  input  logic        weight_ready,
  output logic [31:0] weight_out,
  output logic        weight_valid,
  output logic [1:0]  weight_index,
  output logic [3:0]  load_mask,
  output logic        busy,
  output logic        done,
  output logic        start_error
);

  typedef enum logic [1:0] {
    StIdle,
    StStream,
    StDone
  } state_e;

  state_e      r_state, w_state_next;
  logic [31:0] r_slot [4];
  logic [3:0]  r_load_mask, w_load_mask_next;
  logic [1:0]  r_index, w_index_next;
  logic        r_start_prev;

  logic        w_start_edge;
  logic        w_write_en;
  logic [3:0]  w_write_bit;
  logic        w_load_ok;

  // Previous sample resets to 0, so a start held high through reset release
  // counts as a rising edge on the first sampled cycle.
  assign w_start_edge = start_network_controller & ~r_start_prev;
  assign w_write_en   = writeData & (r_state == StIdle);
  assign w_write_bit  = w_write_en ? (4'b0001 << address) : 4'b0000;

`ifdef WEIGHT_LOAD_CHECK_EN
  logic r_start_error;
  logic w_reject;

  // The mask includes a coincident write so write-then-start in one cycle works.
  assign w_load_ok = ((r_load_mask | w_write_bit) == 4'b1111);
  assign w_reject  = (r_state == StIdle) & w_start_edge & ~w_load_ok;

  // Registered one-cycle pulse for a rejected start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_start_error <= 1'b0;
    end else begin
      r_start_error <= w_reject;
    end
  end

  assign start_error = r_start_error;
`else
  assign w_load_ok   = 1'b1;
  assign start_error = 1'b0;
`endif

  // Start-edge history register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_start_prev <= 1'b0;
    end else begin
      r_start_prev <= start_network_controller;
    end
  end

  // Slot storage: written only in IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        r_slot[i] <= 32'h0;
      end
    end else if (w_write_en) begin
      r_slot[address] <= data_in;
    end
  end

  // FSM, index and load-mask state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= StIdle;
      r_index     <= 2'd0;
      r_load_mask <= 4'b0000;
    end else begin
      r_state     <= w_state_next;
      r_index     <= w_index_next;
      r_load_mask <= w_load_mask_next;
    end
  end

  // Next-state logic: start acceptance, handshake counting, mask clearing.
  always_comb begin
    w_state_next     = r_state;
    w_index_next     = r_index;
    w_load_mask_next = r_load_mask | w_write_bit;
    unique case (r_state)
      StIdle: begin
        if (w_start_edge && w_load_ok) begin
          w_state_next = StStream;
          w_index_next = 2'd0;
        end
      end
      StStream: begin
        if (weight_ready) begin
          if (r_index == 2'd3) begin
            // Last word: no wrap, leave for DONE with the mask cleared.
            w_state_next     = StDone;
            w_index_next     = 2'd0;
            w_load_mask_next = 4'b0000;
          end else begin
            w_index_next = r_index + 2'd1;
          end
        end
      end
      StDone: begin
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  // Outputs decoded from state; the offered word is zero whenever not valid.
  always_comb begin
    weight_valid = (r_state == StStream);
    weight_out   = weight_valid ? r_slot[r_index] : 32'h0;
    weight_index = r_index;
    load_mask    = r_load_mask;
    busy         = (r_state != StIdle);
    done         = (r_state == StDone);
  end

endmodule

// File: tb/tb_weight_bank_streamer.sv
// Scoreboard bench for weight_bank_streamer: stimulus pushes expected
// {index, word} pairs, a negedge monitor pops one per accepted transfer.
module tb_weight_bank_streamer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        writeData = 1'b0;
  logic [31:0] data_in = 32'h0;
  logic        start_network_controller = 1'b0;
  logic        weight_ready = 1'b0;
  logic [31:0] weight_out;
  logic        weight_valid;
  logic [1:0]  weight_index;
  logic [3:0]  load_mask;
  logic        busy;
  logic        done;
  logic        start_error;

  int checks = 0;
  int errors = 0;

  logic [33:0] exp_q[$];
  logic [31:0] m_slot [4];

  weight_bank_streamer dut (
    .clk                      (clk),
    .reset                    (reset),
    .address                  (address),
    .writeData                (writeData),
    .data_in                  (data_in),
    .start_network_controller (start_network_controller),
    .weight_ready             (weight_ready),
    .weight_out               (weight_out),
    .weight_valid             (weight_valid),
    .weight_index             (weight_index),
    .load_mask                (load_mask),
    .busy                     (busy),
    .done                     (done),
    .start_error              (start_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops on every accepted transfer, checks hold stability and idle zero.
  initial begin
    logic        hold_vld;
    logic [33:0] hold_val;
    logic [33:0] e;
    hold_vld = 1'b0;
    hold_val = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        hold_vld = 1'b0;
      end else if (weight_valid) begin
        if (hold_vld) check("hold_stable", {weight_index, weight_out}, hold_val);
        if (weight_ready) begin
          if (exp_q.size() == 0) begin
            check("extra_xfer", {weight_index, weight_out}, 34'h3_FFFF_FFFF);
            if ({weight_index, weight_out} == 34'h3_FFFF_FFFF) begin
              errors++;
              $display("FAIL extra_xfer: unexpected transfer at %0t", $time);
            end
          end else begin
            e = exp_q.pop_front();
            check("xfer", {weight_index, weight_out}, e);
          end
          hold_vld = 1'b0;
        end else begin
          hold_vld = 1'b1;
          hold_val = {weight_index, weight_out};
        end
      end else begin
        check("idle_out_zero", 34'(weight_out), 34'h0);
        hold_vld = 1'b0;
      end
    end
  end

  task automatic do_reset();
    reset = 1'b0;
    writeData = 1'b0;
    start_network_controller = 1'b0;
    weight_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 34'(weight_valid), 34'h0);
    check("rst_out", 34'(weight_out), 34'h0);
    check("rst_mask", 34'(load_mask), 34'h0);
    check("rst_busy_done_err", 34'({busy, done, start_error}), 34'h0);
    for (int i = 0; i < 4; i++) m_slot[i] = 32'h0;
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic write_slot(input logic [1:0] a, input logic [31:0] d);
    address = a;
    data_in = d;
    writeData = 1'b1;
    @(posedge clk);
    #1;
    writeData = 1'b0;
    m_slot[a] = d;
  endtask

  task automatic load_all();
    write_slot(2'd0, 32'h11111111);
    write_slot(2'd1, 32'h22222222);
    write_slot(2'd2, 32'h33333333);
    write_slot(2'd3, 32'h44444444);
    check("mask_full", 34'(load_mask), 34'hF);
  endtask

  // One run: pat bit k is weight_ready in the k-th valid cycle (1 after bit 7).
  task automatic run_stream(input logic [7:0] pat, input int start_len,
                            input bit wr_mid, input bit wr_coin);
    int k;
    int done_cnt;
    int busy_after;
    k = 0;
    done_cnt = 0;
    busy_after = 0;
    if (wr_coin) begin
      address = 2'd0;
      data_in = 32'hCAFEF00D;
      writeData = 1'b1;
      m_slot[0] = 32'hCAFEF00D;
    end
    for (int i = 0; i < 4; i++) exp_q.push_back({2'(i), m_slot[i]});
    start_network_controller = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc + 1 >= start_len) start_network_controller = 1'b0;
      if (wr_mid && cyc == 2) begin
        address = 2'd1;
        data_in = 32'hDEADBEEF;
        writeData = 1'b1;
      end else begin
        writeData = 1'b0;
      end
      if (done) begin
        done_cnt++;
        check("mask_clear_in_done", 34'(load_mask), 34'h0);
      end else if (done_cnt > 0 && busy) begin
        busy_after++;
      end
      if (weight_valid) begin
        weight_ready = (k < 8) ? pat[k] : 1'b1;
        k++;
      end else begin
        weight_ready = 1'b0;
      end
      if (done_cnt > 0 && !done && cyc >= start_len + 2) break;
    end
    check("done_pulses", 34'(done_cnt), 34'd1);
    check("run_drained", 34'(exp_q.size()), 34'd0);
    check("no_restart", 34'(busy_after), 34'd0);
    exp_q.delete();
    weight_ready = 1'b0;
    start_network_controller = 1'b0;
    writeData = 1'b0;
  endtask

  initial begin
    int cnt;
    bit reached;
    do_reset();

    // Basic run, ready always high.
    load_all();
    run_stream(8'hFF, 1, 1'b0, 1'b0);
    check("mask_after_run", 34'(load_mask), 34'h0);

    // Backpressure pattern 1,0,0,1,0,1,1.
    load_all();
    run_stream(8'b0110_1001, 1, 1'b0, 1'b0);

    // Partial load: slots 0..2 only.
    do_reset();
    write_slot(2'd0, 32'h11111111);
    write_slot(2'd1, 32'h22222222);
    write_slot(2'd2, 32'h33333333);
    check("mask_partial", 34'(load_mask), 34'h7);
`ifdef WEIGHT_LOAD_CHECK_EN
    start_network_controller = 1'b1;
    @(posedge clk);
    #1;
    start_network_controller = 1'b0;
    check("start_err_pulse", 34'({start_error, busy}), 34'b10);
    @(posedge clk);
    #1;
    check("start_err_clear", 34'({start_error, busy}), 34'b00);
`else
    run_stream(8'hFF, 1, 1'b0, 1'b0);
`endif

    // Start held 10 cycles with a write attempt mid-stream.
    load_all();
    run_stream(8'hFF, 10, 1'b1, 1'b0);
`ifdef WEIGHT_LOAD_CHECK_EN
    load_all();
`endif
    run_stream(8'hFF, 1, 1'b0, 1'b0);

    // Write to slot 0 coincident with the start edge.
    load_all();
    run_stream(8'hFF, 1, 1'b0, 1'b1);

    // Reset asserted while index 2 is offered.
    load_all();
    exp_q.push_back({2'd0, m_slot[0]});
    exp_q.push_back({2'd1, m_slot[1]});
    start_network_controller = 1'b1;
    weight_ready = 1'b1;
    reached = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      start_network_controller = 1'b0;
      if (weight_valid && weight_index == 2'd2) begin
        reached = 1'b1;
        break;
      end
    end
    check("reach_idx2", 34'(reached), 34'd1);
    weight_ready = 1'b0;
    reset = 1'b0;
    #1;
    check("mid_rst_out", {weight_index, weight_out}, 34'h0);
    check("mid_rst_flags", 34'({weight_valid, busy, done, start_error}), 34'h0);
    check("mid_rst_mask", 34'(load_mask), 34'h0);
    check("mid_rst_drained", 34'(exp_q.size()), 34'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      if (done || busy) cnt++;
    end
    check("no_done_after_rst", 34'(cnt), 34'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
